// File: rtl/mem_scramble_pkg.sv
// mem_scramble_pkg: shared state encoding, key table constants and default widths for the scrambled-memory controller.
package mem_scramble_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_KEY_W  = 16;
  localparam logic [DEF_KEY_W-1:0] KEY_0032 = 16'h0032;
  localparam logic [DEF_KEY_W-1:0] KEY_0087 = 16'h0087;
  localparam logic [DEF_KEY_W-1:0] KEY_1024 = 16'h1024;
  localparam logic [DEF_KEY_W-1:0] KEY_0324 = 16'h0324;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  function automatic logic key_known(input logic [DEF_KEY_W-1:0] k);
    return k inside {KEY_0032, KEY_0087, KEY_1024, KEY_0324};
  endfunction
endpackage

// File: rtl/mem_scramble_ctrl_if.sv
// mem_scramble_ctrl_if: key, host and memory-port signals of the controller; walk_csum exists only with SCRAMBLE_CHECKSUM_EN.
interface mem_scramble_ctrl_if import mem_scramble_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEY_W  = DEF_KEY_W
);
  logic [KEY_W-1:0]  key_in;
  logic              key_valid, key_ready, key_err, walk_done, busy;
  logic              host_req, host_we, host_gnt, host_rvalid;
  logic [ADDR_W-1:0] host_addr, mem_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic              mem_we;
`ifdef SCRAMBLE_CHECKSUM_EN
  logic [DATA_W-1:0] walk_csum;
`endif
  modport slave (
`ifdef SCRAMBLE_CHECKSUM_EN
    output walk_csum,
`endif
    input  key_in, key_valid, host_req, host_we, host_addr, host_wdata, mem_rdata,
    output key_ready, key_err, walk_done, busy, host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_wdata, mem_we
  );
  modport master (
`ifdef SCRAMBLE_CHECKSUM_EN
    input  walk_csum,
`endif
    output key_in, key_valid, host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  key_ready, key_err, walk_done, busy, host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/scramble_xform.sv
// scramble_xform: combinational key-table transform y = f_key(x), all arithmetic mod 2**DATA_W; unknown keys pass x through.
module scramble_xform import mem_scramble_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEY_W  = DEF_KEY_W
) (
  input  logic [KEY_W-1:0]  key,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);
  logic [DATA_W-1:0] y_a, y_b, y_c, y_d, t_c;
  always_comb begin
    y_a = ((x ^ DATA_W'(8'h3F)) + DATA_W'(21)) << 1;
    y_b = ~(((x << 1) + DATA_W'(7)) ^ DATA_W'(8'h5A));
    t_c = (x ^ DATA_W'(8'hA3)) + DATA_W'(17);
    y_c = t_c >> 1;
    y_d = (x + DATA_W'(9)) * DATA_W'(3);
    y = key == KEY_W'(KEY_0032) ? y_a :
        key == KEY_W'(KEY_0087) ? y_b :
        key == KEY_W'(KEY_1024) ? y_c :
        key == KEY_W'(KEY_0324) ? y_d : x;
  end
endmodule

// File: rtl/mem_scramble_ctrl.sv
// mem_scramble_ctrl: host arbiter plus read-transform-write re-keying walk over the scrambled memory; optional walk_csum via SCRAMBLE_CHECKSUM_EN.
module mem_scramble_ctrl import mem_scramble_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEY_W  = DEF_KEY_W
) (
  input logic clk,
  input logic rst_n,
  mem_scramble_ctrl_if.slave bus
);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [KEY_W-1:0]  key;
  logic [DATA_W-1:0] xf;
  logic              idle, known, key_acc, rvalid;
  scramble_xform #(.DATA_W(DATA_W), .KEY_W(KEY_W)) u_xform (.key(key), .x(bus.mem_rdata), .y(xf));
  // reset is gated into every output so nothing reaches memory while rst_n is low
  assign idle           = rst_n && state == IDLE;
  assign known          = key_known(DEF_KEY_W'(bus.key_in));
  assign key_acc        = idle && bus.key_valid && known;
  assign bus.key_ready  = idle;
  assign bus.key_err    = idle && bus.key_valid && !known;
  assign bus.host_gnt   = idle && bus.host_req && !key_acc;
  assign bus.busy       = rst_n && state != IDLE;
  assign bus.walk_done  = rst_n && state == DONE;
  assign bus.mem_we     = (rst_n && state == WR) || (bus.host_gnt && bus.host_we);
  assign bus.mem_addr   = bus.host_gnt ? bus.host_addr : bus.busy ? idx : '0;
  assign bus.mem_wdata  = bus.host_gnt ? bus.host_wdata : xf;
  assign bus.host_rdata = bus.mem_rdata;
  assign bus.host_rvalid = rvalid;
  always_comb begin
    state_nx = key_acc ? RD :
               state == RD ? WR :
               state == WR ? (&idx ? DONE : RD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      key    <= '0;
      rvalid <= 1'b0;
    end else begin
      state  <= state_nx;
      rvalid <= bus.host_gnt && !bus.host_we;
      key    <= key_acc ? bus.key_in : key;
      idx    <= key_acc ? '0 : state == WR ? idx + ADDR_W'(1) : idx;
    end
  end
`ifdef SCRAMBLE_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  assign bus.walk_csum = csum;
  always_ff @(posedge clk) begin
    if (!rst_n) csum <= '0;
    else csum <= key_acc ? '0 : state == WR ? csum ^ xf : csum;
  end
`endif
endmodule

// File: tb/tb_mem_scramble_ctrl.sv
// tb_mem_scramble_ctrl: directed bench with a 1024x32 registered-read memory model behind the controller.
module tb_mem_scramble_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_scramble_ctrl_if #(.ADDR_W(10), .DATA_W(32), .KEY_W(16)) bus ();
  mem_scramble_ctrl #(.ADDR_W(10), .DATA_W(32), .KEY_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] mem [1024];
  int total = 0;
  int bad = 0;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end
  function automatic logic [31:0] model(input logic [15:0] k, input logic [31:0] x);
    case (k)
      16'h0032: return ((x ^ 32'h3F) + 32'd21) << 1;
      16'h0087: return ~(((x << 1) + 32'd7) ^ 32'h5A);
      16'h1024: return ((x ^ 32'hA3) + 32'd17) >> 1;
      16'h0324: return (x + 32'd9) * 32'd3;
      default:  return x;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    bus.key_valid = 1'b0; bus.key_in = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask
  task automatic host_write(input logic [9:0] a, input logic [31:0] d);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
    #1;
    total++; if (bus.host_gnt !== 1'b1) begin bad++; $display("FAIL host_write gnt: got %b want 1", bus.host_gnt); end
    tick();
    quiet();
  endtask
  task automatic host_read(input logic [9:0] a, output logic [31:0] d);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = a;
    #1;
    total++; if (bus.host_gnt !== 1'b1) begin bad++; $display("FAIL host_read gnt: got %b want 1", bus.host_gnt); end
    tick();
    quiet();
    total++; if (bus.host_rvalid !== 1'b1) begin bad++; $display("FAIL host_read rvalid: got %b want 1", bus.host_rvalid); end
    d = bus.host_rdata;
  endtask
  task automatic do_walk(input logic [15:0] k);
    logic [31:0] exp_m [1024];
    int cnt, errs;
`ifdef SCRAMBLE_CHECKSUM_EN
    logic [31:0] csum = '0;
`endif
    for (int i = 0; i < 1024; i++) begin
      exp_m[i] = model(k, mem[i]);
`ifdef SCRAMBLE_CHECKSUM_EN
      csum ^= exp_m[i];
`endif
    end
    bus.key_in = k; bus.key_valid = 1'b1;
    #1;
    total++; if (bus.key_ready !== 1'b1 || bus.key_err !== 1'b0) begin bad++; $display("FAIL walk accept: ready=%b err=%b want 1/0", bus.key_ready, bus.key_err); end
    tick();
    quiet();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL walk busy: got %b want 1", bus.busy); end
    cnt = 1;
    while (bus.walk_done !== 1'b1 && cnt < 3000) begin tick(); cnt++; end
    total++; if (cnt != 2049) begin bad++; $display("FAIL walk cycles key %h: got %0d want 2049", k, cnt); end
    tick();
    total++; if (bus.busy !== 1'b0 || bus.key_ready !== 1'b1 || bus.walk_done !== 1'b0) begin bad++; $display("FAIL walk end: busy=%b ready=%b done=%b want 0/1/0", bus.busy, bus.key_ready, bus.walk_done); end
    errs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_m[i]) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL walk contents key %h: got %0d wrong words want 0", k, errs); end
`ifdef SCRAMBLE_CHECKSUM_EN
    total++; if (bus.walk_csum !== csum) begin bad++; $display("FAIL walk csum: got %h want %h", bus.walk_csum, csum); end
`endif
  endtask
  task automatic test_reset();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    quiet();
    rst_n = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 10'd3; bus.host_wdata = 32'h1234;
    #1;
    total++; if (bus.mem_we !== 1'b0 || bus.host_gnt !== 1'b0) begin bad++; $display("FAIL reset gating: we=%b gnt=%b want 0/0", bus.mem_we, bus.host_gnt); end
    tick(); tick();
    quiet();
    rst_n = 1'b1;
    #1;
    total++; if ({bus.key_ready, bus.busy, bus.walk_done, bus.key_err, bus.host_rvalid, bus.mem_we} !== 6'b100000) begin bad++; $display("FAIL reset outputs: got %b want 100000", {bus.key_ready, bus.busy, bus.walk_done, bus.key_err, bus.host_rvalid, bus.mem_we}); end
    total++; if (bus.mem_addr !== 10'd0) begin bad++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr); end
  endtask
  task automatic test_key_0032();
    logic [31:0] d;
    host_write(10'd5, 32'h0);
    host_read(10'd5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL host readback: got %h want 0", d); end
    do_walk(16'h0032);
    host_read(10'd5, d);
    total++; if (d !== 32'hA8) begin bad++; $display("FAIL key0032 word5: got %h want a8", d); end
  endtask
  task automatic test_key_0087();
    mem[0] = 32'h0;
    do_walk(16'h0087);
    total++; if (mem[0] !== 32'hFFFF_FFA2) begin bad++; $display("FAIL key0087 word0: got %h want ffffffa2", mem[0]); end
  endtask
  task automatic test_key_1024_0324();
    mem[3] = 32'h10;
    do_walk(16'h1024);
    total++; if (mem[3] !== 32'h62) begin bad++; $display("FAIL key1024 word3: got %h want 62", mem[3]); end
    mem[1023] = 32'h1;
    do_walk(16'h0324);
    total++; if (mem[1023] !== 32'h1E) begin bad++; $display("FAIL key0324 word3ff: got %h want 1e", mem[1023]); end
  endtask
  task automatic test_bad_key();
    bus.key_in = 16'h1234; bus.key_valid = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 10'd7; bus.host_wdata = 32'h55;
    #1;
    total++; if ({bus.key_err, bus.host_gnt, bus.mem_we} !== 3'b111) begin bad++; $display("FAIL bad key: err/gnt/we got %b want 111", {bus.key_err, bus.host_gnt, bus.mem_we}); end
    tick();
    quiet();
    #1;
    total++; if ({bus.busy, bus.key_err} !== 2'b00) begin bad++; $display("FAIL bad key after: busy/err got %b want 00", {bus.busy, bus.key_err}); end
    total++; if (mem[7] !== 32'h55) begin bad++; $display("FAIL bad key host write: got %h want 55", mem[7]); end
  endtask
  task automatic test_back_to_back_collision();
    int cnt;
    mem[9] = 32'h0;
    bus.key_in = 16'h0032; bus.key_valid = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 10'd9; bus.host_wdata = 32'hDEAD;
    #1;
    total++; if (bus.host_gnt !== 1'b0) begin bad++; $display("FAIL collision gnt: got %b want 0", bus.host_gnt); end
    tick();
    bus.key_in = 16'h0087;
    #1;
    total++; if ({bus.busy, bus.host_gnt, bus.key_ready, bus.key_err} !== 4'b1000) begin bad++; $display("FAIL mid-walk: busy/gnt/ready/err got %b want 1000", {bus.busy, bus.host_gnt, bus.key_ready, bus.key_err}); end
    repeat (5) tick();
    quiet();
    cnt = 6;
    while (bus.walk_done !== 1'b1 && cnt < 3000) begin tick(); cnt++; end
    total++; if (cnt != 2049) begin bad++; $display("FAIL collision cycles: got %0d want 2049", cnt); end
    tick();
    total++; if (mem[9] !== 32'hA8) begin bad++; $display("FAIL collision word9: got %h want a8", mem[9]); end
  endtask
  task automatic test_reset_mid_walk();
    int errs;
    logic seen_done;
    for (int i = 0; i < 1024; i++) mem[i] = i;
    bus.key_in = 16'h0087; bus.key_valid = 1'b1;
    tick();
    quiet();
    seen_done = 1'b0;
    repeat (200) begin tick(); seen_done |= bus.walk_done; end
    total++; if (bus.mem_addr !== 10'd100 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL mid-walk position: addr=%h we=%b want 064/0", bus.mem_addr, bus.mem_we); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset mid-walk we: got %b want 0", bus.mem_we); end
    tick();
    rst_n = 1'b1;
    repeat (5) begin tick(); seen_done |= bus.walk_done; end
    total++; if (bus.busy !== 1'b0 || seen_done !== 1'b0) begin bad++; $display("FAIL reset mid-walk state: busy=%b done_seen=%b want 0/0", bus.busy, seen_done); end
    errs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== (i < 100 ? model(16'h0087, i) : 32'(i))) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL reset mid-walk contents: got %0d wrong words want 0", errs); end
  endtask
  initial begin
    test_reset();
    test_key_0032();
    test_key_0087();
    test_key_1024_0324();
    test_bad_key();
    test_back_to_back_collision();
    test_reset_mid_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
